// File: rtl/ysyx_23060221_clint.sv
// Machine timer (mtime) as an AXI4 read slave; a low-word read snapshots all 64 bits for a tear-free high read.
// Define CLINT_WRITE_EN to add an AXI4 write channel that loads either mtime half.
module ysyx_23060221_clint #(
    parameter logic [31:0] BASE = 32'h0200_0000,
    parameter int unsigned DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
`ifdef CLINT_WRITE_EN
    ,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid
`endif
);

    localparam logic [31:0] BASE_HI = BASE + 32'd4;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    rd_state_t        rd_state;
    logic [63:0]      mtime;
    logic [63:0]      snap;
    logic             snap_vld;
    logic [CNT_W-1:0] cnt;

    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;
    logic        fixed_q;
    logic        size_ok_q;

    logic        ar_hs;
    logic        r_hs;
    logic        r_next;
    logic [31:0] next_addr;
    logic        cap_en;
    logic [31:0] cap_addr;
    logic        cap_ok;
    logic        cap_lo;
    logic        cap_hi;
    logic [31:0] cap_data;
    logic [1:0]  cap_resp;

    logic        wr_en;
    logic [63:0] wr_value;

    assign ar_hs     = arvalid & arready;
    assign r_hs      = rvalid & rready;
    assign r_next    = r_hs & (beat_q != len_q);
    assign next_addr = fixed_q ? addr_q : addr_q + 32'd4;

    // A beat's data is captured either at the AR handshake or when the previous beat is accepted.
    assign cap_en   = ar_hs | r_next;
    assign cap_addr = ar_hs ? araddr : next_addr;
    assign cap_ok   = ar_hs ? (arsize == 3'b010) : size_ok_q;
    assign cap_lo   = cap_ok & (cap_addr == BASE);
    assign cap_hi   = cap_ok & (cap_addr == BASE_HI);

    always_comb begin
        cap_data = 32'd0;
        cap_resp = 2'b10;
        if (cap_lo) begin
            cap_data = mtime[31:0];
            cap_resp = 2'b00;
        end else if (cap_hi) begin
            cap_data = snap_vld ? snap[63:32] : mtime[63:32];
            cap_resp = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
            cnt   <= '0;
        end else if (wr_en) begin
            mtime <= wr_value;
            cnt   <= '0;
        end else if (cnt == CNT_MAX) begin
            mtime <= mtime + 64'd1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap     <= '0;
            snap_vld <= 1'b0;
        end else if (cap_en & cap_lo) begin
            snap     <= mtime;
            snap_vld <= 1'b1;
        end else if (cap_en & cap_hi) begin
            snap_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= '0;
            rdata     <= '0;
            rid       <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            fixed_q   <= 1'b0;
            size_ok_q <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_hs) begin
                        rd_state  <= R_DATA;
                        arready   <= 1'b0;
                        rvalid    <= 1'b1;
                        addr_q    <= araddr;
                        len_q     <= arlen;
                        beat_q    <= 8'd0;
                        fixed_q   <= (arburst == 2'b00);
                        size_ok_q <= (arsize == 3'b010);
                        rid       <= arid;
                        rlast     <= (arlen == 8'd0);
                        rdata     <= cap_data;
                        rresp     <= cap_resp;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (beat_q == len_q) begin
                            rd_state <= R_IDLE;
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                            rlast  <= ((beat_q + 8'd1) == len_q);
                            rdata  <= cap_data;
                            rresp  <= cap_resp;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

`ifdef CLINT_WRITE_EN
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    wr_state_t   wr_state;
    logic [31:0] waddr_q;
    logic        wok_q;
    logic        unused_w;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Single-beat writes only, so the burst type and wlast carry no information.
    assign unused_w = ^{awburst, wlast};
    assign wr_en    = (wr_state == W_DATA) & wvalid & wready & wok_q;
    assign wr_value = (waddr_q == BASE) ? {mtime[63:32], merge_bytes(mtime[31:0], wdata, wstrb)}
                                        : {merge_bytes(mtime[63:32], wdata, wstrb), mtime[31:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= '0;
            bid      <= '0;
            waddr_q  <= '0;
            wok_q    <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid & awready) begin
                        wr_state <= W_DATA;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        bid      <= awid;
                        waddr_q  <= awaddr;
                        wok_q    <= (awlen == 8'd0) && (awsize == 3'b010) &&
                                    ((awaddr == BASE) || (awaddr == BASE_HI));
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        wr_state <= W_RESP;
                        wready   <= 1'b0;
                        bvalid   <= 1'b1;
                        bresp    <= wok_q ? 2'b00 : 2'b10;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wr_state <= W_IDLE;
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end
`else
    assign wr_en    = 1'b0;
    assign wr_value = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060221_clint.sv
// Scoreboard bench for the CLINT mtime slave: beats are predicted at each capture edge and checked on transfer.
`timescale 1ns/1ps
module tb_ysyx_23060221_clint;

    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam logic [31:0] BASE_HI = 32'h0200_0004;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arready, arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        rready = 1'b0;
    logic        rvalid, rlast;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [3:0]  rid;
`ifdef CLINT_WRITE_EN
    logic        awready, awvalid = 1'b0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'b010;
    logic [1:0]  awburst = 2'b01;
    logic        wready, wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b1;
    logic        bready = 1'b0;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
`endif

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    logic [63:0] m_time;
    logic [63:0] m_snap = '0;
    logic        m_snap_vld = 1'b0;
    logic        m_load = 1'b0;
    logic [63:0] m_load_val = '0;
    logic [31:0] cur_addr = '0;
    logic [7:0]  cur_len = '0, cur_beat = '0;
    logic        cur_fixed = 1'b0, cur_ok = 1'b0;
    logic [3:0]  cur_id = '0;
    logic        ar_hs = 1'b0;

    ysyx_23060221_clint dut (
        .clk(clk), .rst(rst),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
        .rlast(rlast), .rid(rid)
`ifdef CLINT_WRITE_EN
        ,
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid)
`endif
    );

    always #5 clk = ~clk;

    // Reference timer for DIV=1: one tick per clock, overridden by a predicted write.
    always @(posedge clk) begin
        if (rst) m_time <= 64'd0;
        else if (m_load) m_time <= m_load_val;
        else m_time <= m_time + 64'd1;
    end

    function automatic beat_t model_beat(input logic [31:0] a, input logic ok, input logic last,
                                         input logic [3:0] id);
        beat_t b;
        b.data = 32'd0; b.resp = 2'b10; b.last = last; b.id = id;
        if (ok && a == BASE) begin
            b.data = m_time[31:0]; b.resp = 2'b00;
            m_snap = m_time; m_snap_vld = 1'b1;
        end else if (ok && a == BASE_HI) begin
            b.data = m_snap_vld ? m_snap[63:32] : m_time[63:32]; b.resp = 2'b00;
            m_snap_vld = 1'b0;
        end
        return b;
    endfunction

    // Called at a negedge: predict what the coming posedge captures, then advance one cycle.
    task automatic tick();
        ar_hs = 1'b0;
        if (!rst) begin
            if (arvalid && arready) begin
                ar_hs = 1'b1;
                cur_addr = araddr; cur_len = arlen; cur_beat = 8'd0; cur_id = arid;
                cur_fixed = (arburst == 2'b00); cur_ok = (arsize == 3'b010);
                exp_q.push_back(model_beat(cur_addr, cur_ok, cur_len == 8'd0, cur_id));
            end else if (rvalid && rready && cur_beat != cur_len) begin
                cur_beat = cur_beat + 8'd1;
                if (!cur_fixed) cur_addr = cur_addr + 32'd4;
                exp_q.push_back(model_beat(cur_addr, cur_ok, cur_beat == cur_len, cur_id));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt, output logic ok);
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1; ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            ok = ar_hs;
        end
        arvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (arready !== 1'b0 || rvalid !== 1'b0 || rlast !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: arready=%b rvalid=%b rlast=%b expected 0 0 0", arready, rvalid, rlast);
        end
        checks++;
        if (rdata !== 32'd0 || rresp !== 2'b00 || rid !== 4'd0) begin
            errors++; $display("FAIL reset_data: rdata=%h rresp=%b rid=%h expected 0", rdata, rresp, rid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (arready !== 1'b1) begin
            errors++; $display("FAIL reset_release_arready: got %b expected 1", arready);
        end
    endtask

    task automatic test_first_read();
        logic ok;
        beat_t e;
        rready = 1'b1;
        repeat (9) tick();
        issue_ar(BASE, 4'h3, 8'd0, 3'b010, 2'b01, ok);
        checks++;
        if (!ok || rvalid !== 1'b1) begin
            errors++; $display("FAIL first_latency: rvalid=%b handshake=%b expected 1 1", rvalid, ok);
        end
        checks++;
        if (rdata !== 32'd10 || rresp !== 2'b00 || rlast !== 1'b1 || rid !== 4'h3) begin
            errors++; $display("FAIL first_beat: rdata=%0d rresp=%b rlast=%b rid=%h expected 10 00 1 3", rdata, rresp, rlast, rid);
        end
        if (rvalid && rready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL first_sb: unexpected beat rdata=%h", rdata);
            end else begin
                e = exp_q.pop_front();
                if ({rdata, rresp, rlast, rid} !== e) begin
                    errors++; $display("FAIL first_sb: got %h/%b/%b/%h expected %h/%b/%b/%h", rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                end
            end
        end
        tick();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL first_end: rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
    endtask

    // Multi-beat burst with rready held high; checks every beat and the return to idle.
    task automatic test_burst(input string name, input logic [31:0] a, input logic [3:0] id,
                              input logic [7:0] len, input logic [1:0] bt);
        logic ok, done;
        int nb;
        beat_t e;
        rready = 1'b1;
        issue_ar(a, id, len, 3'b010, bt, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s_ar_timeout: handshake=%b expected 1", name, ok);
        end
        done = 1'b0; nb = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (rvalid && rready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s_beat%0d: unexpected beat rdata=%h", name, nb, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({rdata, rresp, rlast, rid} !== e) begin
                        errors++; $display("FAIL %s_beat%0d: got %h/%b/%b/%h expected %h/%b/%b/%h", name, nb, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                    end
                end
                nb++;
                done = rlast;
            end
            tick();
        end
        checks++;
        if (nb != int'(len) + 1 || arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL %s_end: beats=%0d arready=%b rvalid=%b expected %0d 1 0", name, nb, arready, rvalid, int'(len) + 1);
        end
    endtask

    task automatic test_errors();
        logic ok;
        beat_t e;
        rready = 1'b1;
        issue_ar(32'h0200_0008, 4'h5, 8'd0, 3'b010, 2'b01, ok);
        checks++;
        if (!ok || rresp !== 2'b10 || rdata !== 32'd0 || rid !== 4'h5) begin
            errors++; $display("FAIL bad_addr: rresp=%b rdata=%h rid=%h expected 10 0 5", rresp, rdata, rid);
        end
        e = exp_q.pop_front();
        tick();
        issue_ar(BASE, 4'h6, 8'd0, 3'b001, 2'b01, ok);
        checks++;
        if (!ok || rresp !== 2'b10 || rdata !== 32'd0 || rid !== 4'h6) begin
            errors++; $display("FAIL bad_size: rresp=%b rdata=%h rid=%h expected 10 0 6", rresp, rdata, rid);
        end
        e = exp_q.pop_front();
        tick();
        checks++;
        if (exp_q.size() != 0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL errors_end: queue=%0d rvalid=%b expected 0 0", exp_q.size(), rvalid);
        end
    endtask

    task automatic test_stall();
        logic ok;
        logic [31:0] d0;
        logic l0;
        beat_t e;
        rready = 1'b0;
        issue_ar(BASE, 4'hC, 8'd0, 3'b010, 2'b01, ok);
        d0 = rdata; l0 = rlast;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== d0 || rlast !== l0 || rid !== 4'hC) begin
                errors++; $display("FAIL stall_hold%0d: rvalid=%b rdata=%h rlast=%b expected 1 %h %b", c, rvalid, rdata, rlast, d0, l0);
            end
        end
        rready = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL stall_sb: unexpected beat rdata=%h", rdata);
        end else begin
            e = exp_q.pop_front();
            if ({rdata, rresp, rlast, rid} !== e) begin
                errors++; $display("FAIL stall_sb: got %h/%b/%b/%h expected %h/%b/%b/%h", rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
            end
        end
        tick();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL stall_end: rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
    endtask

    task automatic test_rst_mid_burst();
        logic ok;
        beat_t e;
        rready = 1'b1;
        issue_ar(BASE, 4'h7, 8'd3, 3'b010, 2'b01, ok);
        tick();
        rready = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'd0 || arready !== 1'b0) begin
            errors++; $display("FAIL rst_abort: rvalid=%b rlast=%b rdata=%h arready=%b expected 0 0 0 0", rvalid, rlast, rdata, arready);
        end
        exp_q.delete();
        m_snap_vld = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_rearm: arready=%b rvalid=%b expected 1 0", arready, rvalid);
        end
        rready = 1'b1;
        issue_ar(BASE, 4'h2, 8'd0, 3'b010, 2'b01, ok);
        checks++;
        if (!ok || rdata !== 32'd1 || rresp !== 2'b00) begin
            errors++; $display("FAIL rst_mtime_cleared: rdata=%0d rresp=%b expected 1 00", rdata, rresp);
        end
        e = exp_q.pop_front();
        tick();
    endtask

`ifdef CLINT_WRITE_EN
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] sz, input logic [3:0] id,
                            output logic [1:0] resp, output logic [3:0] id_o, output logic ok);
        logic [63:0] v;
        resp = 2'bxx; id_o = 4'hx; ok = 1'b0;
        awaddr = a; awid = id; awlen = 8'd0; awsize = sz; awburst = 2'b01; awvalid = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            ok = awready;
            tick();
        end
        awvalid = 1'b0;
        if (!ok) return;
        ok = 1'b0; wdata = d; wstrb = s;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (wready) begin
                v = m_time;
                for (int i = 0; i < 4; i++) begin
                    if (s[i] && a == BASE) v[8*i +: 8] = d[8*i +: 8];
                    if (s[i] && a == BASE_HI) v[32 + 8*i +: 8] = d[8*i +: 8];
                end
                m_load = (sz == 3'b010) && (a == BASE || a == BASE_HI);
                m_load_val = v;
                wvalid = 1'b1;
                ok = 1'b1;
            end
            tick();
            wvalid = 1'b0; m_load = 1'b0;
        end
        if (!ok) return;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bvalid) begin
                resp = bresp; id_o = bid; bready = 1'b1; ok = 1'b1;
            end
            tick();
            bready = 1'b0;
        end
    endtask

    task automatic test_write();
        logic ok;
        logic [1:0] resp;
        logic [3:0] bid_o;
        beat_t e;
        rready = 1'b1;
        do_write(BASE_HI, 32'h0, 4'hF, 3'b010, 4'hA, resp, bid_o, ok);
        checks++;
        if (!ok || resp !== 2'b00 || bid_o !== 4'hA) begin
            errors++; $display("FAIL wr_hi: done=%b bresp=%b bid=%h expected 1 00 a", ok, resp, bid_o);
        end
        do_write(BASE, 32'h1234_5678, 4'hF, 3'b001, 4'hD, resp, bid_o, ok);
        checks++;
        if (!ok || resp !== 2'b10 || bid_o !== 4'hD) begin
            errors++; $display("FAIL wr_bad_size: done=%b bresp=%b bid=%h expected 1 10 d", ok, resp, bid_o);
        end
        // Low-word write with the AR issued on the very next cycle so it sees 0xFFFF_FFFF.
        awaddr = BASE; awid = 4'hB; awlen = 8'd0; awsize = 3'b010; awvalid = 1'b1; ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            ok = awready;
            tick();
        end
        awvalid = 1'b0;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        for (int c = 0; c < 20 && ok && !wvalid; c++) begin
            if (wready) begin
                wvalid = 1'b1; m_load = 1'b1; m_load_val = {m_time[63:32], 32'hFFFF_FFFF};
                tick();
                m_load = 1'b0;
            end else begin
                tick();
            end
        end
        checks++;
        if (!ok || !wvalid) begin
            errors++; $display("FAIL wr_lo_timeout: aw=%b w=%b expected 1 1", ok, wvalid);
        end
        wvalid = 1'b0;
        araddr = BASE; arid = 4'h1; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'hB) begin
            errors++; $display("FAIL wr_lo_resp: bvalid=%b bresp=%b bid=%h expected 1 00 b", bvalid, bresp, bid);
        end
        bready = 1'b1;
        tick();
        arvalid = 1'b0; bready = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wr_read_lo: rvalid=%b rdata=%h expected 1 ffffffff", rvalid, rdata);
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        tick();
        issue_ar(BASE_HI, 4'h2, 8'd0, 3'b010, 2'b01, ok);
        checks++;
        if (!ok || rdata !== 32'd0 || rresp !== 2'b00) begin
            errors++; $display("FAIL wr_snapshot_hi: rdata=%h rresp=%b expected 0 00", rdata, rresp);
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_first_read();
        test_burst("incr2", BASE, 4'h4, 8'd1, 2'b01);
        test_errors();
        test_stall();
        test_burst("incr4", BASE, 4'h8, 8'd3, 2'b01);
        test_burst("fixed2", BASE, 4'h9, 8'd1, 2'b00);
        test_burst("hi_live", BASE_HI, 4'hE, 8'd0, 2'b01);
`ifdef CLINT_WRITE_EN
        test_write();
`endif
        test_rst_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_23060221_clint.md
Name:
ysyx_23060221_clint

Overview:
- AXI4 read slave holding the 64-bit machine timer (mtime) for the core.
- Sits directly downstream of the bus arbiter: its clint_ar*/clint_r* outputs drive this block.
- The arbiter routes EXU reads of the mtime low word (BASE) and high word (BASE+4) here.
- Provides a tear-free 64-bit read via a low-word snapshot.

Parameters:
BASE  32'h0200_0000  byte address of mtime[31:0]; BASE+4 is mtime[63:32]
DIV  1  prescaler; mtime increments once every DIV clk cycles (DIV>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arready  out  1  AR ready
arvalid  in  1  AR valid
araddr  in  32  read byte address
arid  in  4  read transaction ID
arlen  in  8  burst length minus one
arsize  in  3  beat size; only 3'b010 is legal
arburst  in  2  2'b00 FIXED, 2'b01 INCR; other codes treated as INCR
rready  in  1  R ready
rvalid  out  1  R valid
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
rdata  out  32  read data
rlast  out  1  last beat of the burst
rid  out  4  echoes the latched arid

Behaviour:
- Reset (rst high at a clk edge):
  - mtime=0, prescale count=0, snapshot valid flag=0, FSM=IDLE.
  - rvalid=0, rlast=0, rresp=0, rdata=0, rid=0.
  - arready=0 while rst is high; arready=1 on the first cycle after rst falls.
- Timer:
  - The prescale count runs 0..DIV-1. When count==DIV-1, mtime increments and count goes to 0.
  - 64-bit wrap: all-ones -> 0.
- FSM IDLE (arready=1):
  - On arvalid&arready, latch arid, araddr, arlen, arburst and the arsize legality; beat count=0; go to DATA.
  - First-beat data is captured at that same edge, so rvalid rises in the next cycle (1-cycle latency).
- FSM DATA (arready=0, rvalid=1):
  - rdata, rresp, rlast and rid stay stable while rvalid&~rready.
  - On rvalid&rready with beat==arlen: go to IDLE, rvalid=0 next cycle.
  - On rvalid&rready otherwise: beat+1. Address +4 for INCR (wraps within 32 bits); unchanged for FIXED. The next beat's data is captured at that edge.
  - rlast = (beat==arlen).
- Beat data:
  - Address == BASE: rdata = mtime[31:0], taken as the pre-increment value at the capture edge. The full 64-bit mtime is copied to the snapshot and the valid flag is set.
  - Address == BASE+4: rdata = snapshot[63:32] if the valid flag is set, else live mtime[63:32]. The valid flag is cleared.
  - Any other address, or arsize != 3'b010: rdata=0, rresp=2'b10, and the snapshot is untouched.
- Simultaneous increment and capture: the captured value is the value before the increment.
- rst mid-burst: the burst is aborted with no further beats. rvalid=0 from the edge where rst is sampled.

Optional Feature:
CLINT_WRITE_EN
- Defined:
  - Adds write ports: awready, awvalid, awaddr[31:0], awid[3:0], awlen[7:0], awsize[2:0], awburst[1:0], wready, wvalid, wdata[31:0], wstrb[3:0], wlast, bready, bvalid, bresp[1:0], bid[3:0].
  - An independent write FSM cycles AW -> W -> B. awready=1 in its idle state; wready=1 after AW is accepted.
  - On the W handshake, the addressed mtime half is updated with wstrb as a byte mask. A write beats the increment in the same cycle, and the prescale count resets to 0.
  - bvalid rises the cycle after the W handshake and is held until bready; bid=awid.
  - awlen!=0, a bad address, or awsize!=3'b010: no update, bresp=2'b10.
  - A read capture in the same cycle as a write sees the pre-write value.
- Not defined:
  - The write ports are absent and mtime is read-only.

Test Plan:
- DIV=1; release rst, AR at BASE handshaken 10 cycles later -> rvalid 1 cycle after the handshake, rdata=10, rresp=0, rlast=1, rid=arid.
- CLINT_WRITE_EN: write low=0xFFFF_FFFF, high=0; read BASE then BASE+4 while mtime increments -> high rdata=0 (snapshot), not 1.
- arlen=1, INCR, BASE, rready=1 -> 2 beats, rlast only on beat 2, beat 2 = snapshot high, arready=1 the cycle after beat 2.
- AR at 0x0200_0008, arid=4'h5 -> rresp=2'b10, rdata=0, rid=4'h5; then AR with arsize=3'b001 at BASE -> rresp=2'b10.
- rready held low 5 cycles during a beat -> rvalid, rdata and rlast stay constant; transfer completes on the first rready=1 edge.
- rst asserted mid-burst of arlen=3 -> rvalid=0 next cycle, mtime=0; arready=1 the cycle after rst falls.
